// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding and PC constants.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        EXC   = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP            = 32'd4;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'd64;

endpackage

// File: rtl/fetch_fault_chk.sv
// Flags a fetch address that is not word-aligned or lies outside the populated instruction space.
module fetch_fault_chk #(
    parameter logic [31:0] IMEM_BYTES = 32'd80
) (
    input  logic [31:0] pc,
    output logic        illegal
);

    assign illegal = (pc[1:0] != 2'b00) || (pc >= IMEM_BYTES);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers fetched words into a one-entry IF/ID stage,
// and applies redirects, exception requests and fetch-fault vectoring.
module imem_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
    parameter logic [31:0] IMEM_BYTES = 32'd80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    output logic [31:0] epc,
    output logic        fetch_fault,
    output logic [1:0]  state
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic         illegal;
    logic         handshake;
    logic         stage_free;

    fetch_fault_chk #(
        .IMEM_BYTES(IMEM_BYTES)
    ) u_fault_chk (
        .pc     (pc_q),
        .illegal(illegal)
    );

    // Output handshake: a word transfers on any clock edge where out_valid and out_ready are
    // both 1; out_valid/out_pc/out_instr stay stable while out_valid=1 and out_ready=0.
    assign handshake  = out_valid && out_ready;
    assign stage_free = !out_valid || out_ready;

    assign imem_pc = pc_q;
    assign state   = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= 32'd0;
            out_pc      <= 32'd0;
            epc         <= 32'd0;
            fetch_fault <= 1'b0;
        end else begin
            fetch_fault <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                    end
                    // An exception seen while paused is recorded but does not start fetching.
                    if (exc_req) begin
                        epc  <= exc_pc;
                        pc_q <= EXC_VECTOR;
                    end else begin
                        if (redirect_valid) begin
                            pc_q <= redirect_pc;
                        end
                        if (fetch_en) begin
                            state_q <= FETCH;
                        end
                    end
                end

                FETCH, HOLD: begin
                    if (exc_req) begin
                        epc       <= exc_pc;
                        out_valid <= 1'b0;
                        state_q   <= EXC;
                    end else if (redirect_valid) begin
                        pc_q      <= redirect_pc;
                        out_valid <= 1'b0;
                        state_q   <= FETCH;
                    end else if (!fetch_en) begin
                        if (handshake) begin
                            out_valid <= 1'b0;
                        end
                        state_q <= IDLE;
                    end else if (stage_free) begin
                        if (illegal) begin
                            epc         <= pc_q;
                            fetch_fault <= 1'b1;
                            out_valid   <= 1'b0;
                            state_q     <= EXC;
                        end else begin
                            out_instr <= imem_instruction;
                            out_pc    <= pc_q;
                            out_valid <= 1'b1;
                            pc_q      <= pc_q + PC_STEP;
                            state_q   <= FETCH;
                        end
                    end else begin
                        state_q <= HOLD;
                    end
                end

                EXC: begin
                    out_valid <= 1'b0;
                    pc_q      <= EXC_VECTOR;
                    if (exc_req) begin
                        epc <= exc_pc;
                    end else if (fetch_en) begin
                        state_q <= FETCH;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the combinational instruction memory (address in, 32-bit word out, same cycle). It registers each fetched word into a one-entry IF/ID output stage with a valid/ready handshake. It applies branch/jump redirects and exception requests, and detects misaligned or out-of-range fetches, vectoring them to the exception handler at EXC_VECTOR.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset
EXC_VECTOR, 32'd64, exception handler address; must be word-aligned and < IMEM_BYTES
IMEM_BYTES, 32'd80, size of the populated instruction space; a fetch at or above this address faults

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fetch_en  input  1  1 = fetching allowed; 0 = pause
imem_pc  output  32  address to instruction memory; always equals pc_q
imem_instruction  input  32  word returned by instruction memory for imem_pc
out_valid  output  1  out_instr/out_pc hold a valid fetched instruction
out_ready  input  1  downstream accepts the output this cycle
out_instr  output  32  registered instruction word
out_pc  output  32  address of out_instr
redirect_valid  input  1  branch/jump taken; 1-cycle request
redirect_pc  input  32  redirect target
exc_req  input  1  external exception request; 1-cycle pulse
exc_pc  input  32  faulting PC accompanying exc_req
epc  output  32  captured exception PC
fetch_fault  output  1  1-cycle pulse on a fetch fault
state  output  2  current FSM state, for debug

Behaviour:
- Reset (reset=0, asynchronous): pc_q=RESET_PC, out_valid=0, out_instr=0, out_pc=0, epc=0, fetch_fault=0, state=IDLE.
- States: IDLE=0, FETCH=1, HOLD=2, EXC=3.
- IDLE: no capture, pc_q held. Go to FETCH when fetch_en=1. Outputs stay readable, and out_valid clears on out_ready.
- A fetch is legal when pc_q[1:0]==0 and pc_q < IMEM_BYTES.
- FETCH with a free stage (out_valid=0, or out_ready=1):
  - legal fetch: out_instr<=imem_instruction, out_pc<=pc_q, out_valid<=1, pc_q<=pc_q+4 (32-bit wrap).
  - illegal fetch: no capture, epc<=pc_q, fetch_fault<=1 for one cycle, out_valid<=0 (once the pending output is consumed), go to EXC.
- FETCH with out_valid=1 and out_ready=0: go to HOLD. Outputs and pc_q are frozen.
- HOLD: all state frozen until out_ready=1. That cycle is a handshake, and the FSM goes to FETCH next.
- fetch_en=0 in FETCH or HOLD: go to IDLE after the current output is held or consumed. No new capture.
- EXC: lasts one cycle. out_valid=0, pc_q<=EXC_VECTOR, then FETCH (or IDLE if fetch_en=0).
- Latency: instruction at address A appears on out_instr one clock after pc_q==A. Throughput is 1 instruction/cycle when unstalled.
- Priority within a cycle, highest first: exc_req > redirect_valid > fetch fault > normal fetch/hold.
  - exc_req (any state except IDLE): epc<=exc_pc, out_valid<=0 (flush, even in HOLD), go to EXC.
  - redirect_valid (FETCH/HOLD): pc_q<=redirect_pc, out_valid<=0 (flush uncommitted output), state<=FETCH. No capture that cycle.
  - A misaligned or out-of-range redirect target faults on the following fetch cycle.
- Requests arriving in IDLE: redirect_valid updates pc_q; exc_req is recorded (epc, pc_q<=EXC_VECTOR) without leaving IDLE.
- fetch_fault is never asserted in IDLE or EXC.
- Arithmetic: all PC values are 32-bit unsigned. No exception is taken on +4 wrap; the range check catches the overrun.

Decomposition:
- Shared package mips_fetch_pkg holds:
  - the state encoding (IDLE/FETCH/HOLD/EXC, 2-bit)
  - PC_STEP=4
  - default EXC_VECTOR=32'd64
- Optional sub-module fetch_fault_chk: combinational; takes pc and IMEM_BYTES, outputs the illegal flag. Everything else lives in a single module.

Test Plan:
1. Release reset, fetch_en=1, out_ready=1 -> out_pc 0 / out_instr 0x2108000A, then out_pc 4 / 0x20090005 on consecutive cycles; state=FETCH.
2. out_ready=0 for 3 cycles while out_pc=8 -> out_instr/out_pc held, imem_pc stays 12, state=HOLD; out_ready=1 -> out_pc 12 next cycle.
3. redirect_valid with redirect_pc=40 during HOLD -> out_valid=0 next cycle, then out_pc 40 / out_instr 0x20080004.
4. redirect_pc=42 -> fetch_fault pulses once, epc=42, EXC for 1 cycle, then out_pc=64.
5. With IMEM_BYTES=80, fetch sequentially from 72 -> out_pc 72 and 76 delivered, then fault with epc=80 and vector to 64. exc_req with exc_pc=36 in the same cycle as a redirect -> epc=36, redirect ignored, next out_pc=64.
6. Assert reset low mid-HOLD (asynchronous, between edges) -> out_valid, out_instr, out_pc, epc, fetch_fault all 0 immediately; imem_pc=0; state=IDLE.
